// File: rtl/serial_alu_pkg.sv
// serial_alu_pkg: shared types and helpers for the bit-serial ALU sequencer.
//   op_t    - opcode encoding carried on the input handshake
//   state_t - sequencer FSM state, also exported on the debug state port
//   clog2   - width of the bit counter for a given operand width
package serial_alu_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/serial_alu_seq_if.sv
// serial_alu_seq_if: operand and result handshakes of the serial ALU.
//
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid && ready are both 1. The source holds valid and its payload
// stable until that edge; ready never depends combinationally on valid.
//
//   in_valid/in_ready : operand channel, payload op, a, b
//   out_valid/out_ready : result channel, payload result, carry
//                         (plus zero, ovf when SERIAL_ALU_FLAGS_EN is defined)
// master = operand source / result consumer, slave = the sequencer.
interface serial_alu_seq_if
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  op_t              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;

`ifdef SERIAL_ALU_FLAGS_EN
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, carry, zero, ovf
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, carry, zero, ovf
  );
`else
  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, carry
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, carry
  );
`endif

endinterface

// File: rtl/alu_bit_slice.sv
// alu_bit_slice: purely combinational one-bit ALU slice.
//   a, b : operand bits (b already inverted by the caller for SUB)
//   cin  : carry into this bit
//   op   : opcode
//   y    : logic / sum output
//   cout : carry out (always 0 for AND/OR)
module alu_bit_slice
  import serial_alu_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  op_t  op,
  output logic y,
  output logic cout
);

  always_comb begin
    y    = 1'b0;
    cout = 1'b0;
    unique case (op)
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      default: begin
        // ADD and SUB are the same full adder; SUB differs only in b' and cin seed
        y    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
      end
    endcase
  end

endmodule

// File: rtl/serial_alu_seq.sv
// serial_alu_seq: bit-serial ALU sequencer.
// Captures an operand pair on the input handshake, streams it LSB-first
// through one alu_bit_slice (carry kept in carry_q between bits), and
// presents the reassembled result on the output handshake.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : serial_alu_seq_if.slave (operand and result channels)
//   state      : current FSM state, for debug/observation
//
// Optional build macro SERIAL_ALU_FLAGS_EN adds the zero and ovf flags,
// registered on entry to DONE and held with the result.
module serial_alu_seq
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_alu_seq_if.slave   bus,
  output state_t            state
);

  localparam int CW = clog2(WIDTH);

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  op_t              op_q;
  logic             carry_q;

  logic             arith;
  logic             b_bit;
  logic             y;
  logic             cout;
  logic [WIDTH-1:0] result_next;

  assign arith       = (op_q == OP_ADD) || (op_q == OP_SUB);
  // Two's-complement subtract: a + ~b + 1, with the +1 seeded into carry_q
  assign b_bit       = b_q[0] ^ (op_q == OP_SUB);
  assign result_next = {y, result_q[WIDTH-1:1]};

  alu_bit_slice u_slice (
    .a    (a_q[0]),
    .b    (b_bit),
    .cin  (carry_q),
    .op   (op_q),
    .y    (y),
    .cout (cout)
  );

`ifdef SERIAL_ALU_FLAGS_EN
  logic zero_q;
  logic ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      op_q     <= OP_AND;
      carry_q  <= 1'b0;
`ifdef SERIAL_ALU_FLAGS_EN
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            op_q    <= bus.op;
            cnt_q   <= '0;
            carry_q <= (bus.op == OP_SUB);
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          // Operand registers shift right so the current bit is always at [0]
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          result_q <= result_next;
          carry_q  <= arith & cout;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= S_DONE;
`ifdef SERIAL_ALU_FLAGS_EN
            zero_q  <= (result_next == '0);
            // At the MSB, carry_q is the carry into it and cout the carry out
            ovf_q   <= arith & (carry_q ^ cout);
`endif
          end
        end
        S_DONE: begin
          if (bus.out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
`ifdef SERIAL_ALU_FLAGS_EN
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
`endif
  assign state         = state_q;

endmodule

// File: tb/tb_serial_alu_seq.sv
// tb_serial_alu_seq: self-checking bench for serial_alu_seq (WIDTH=8).
// Expected results are computed by a behavioural model when operands are
// driven, queued, and compared when the DUT presents a result.
module tb_serial_alu_seq;
  import serial_alu_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst_n;
  state_t state;

  always #5 clk = ~clk;

  serial_alu_seq_if #(.WIDTH(W)) bus ();

  serial_alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .state (state)
  );

  // ---------------- scoreboard ----------------
  // packed as {ovf, zero, carry, result}
  logic [W+2:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [W+2:0] model(input logic [1:0] o, input logic [W-1:0] av,
                                         input logic [W-1:0] bv);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c;
    logic         v;
    s = '0;
    case (o)
      2'b00: begin r = av & bv; c = 1'b0; v = 1'b0; end
      2'b01: begin r = av | bv; c = 1'b0; v = 1'b0; end
      2'b10: begin
        s = {1'b0, av} + {1'b0, bv};
        r = s[W-1:0];
        c = s[W];
        v = (av[W-1] == bv[W-1]) && (r[W-1] != av[W-1]);
      end
      default: begin
        s = {1'b0, av} + {1'b0, ~bv} + 1;
        r = s[W-1:0];
        c = s[W];
        v = (av[W-1] != bv[W-1]) && (r[W-1] != av[W-1]);
      end
    endcase
    return {v, (r == '0), c, r};
  endfunction

  task automatic check_out(input string pfx, input logic [W+2:0] e);
    check({pfx, "_result"}, bus.result, e[W-1:0]);
    check({pfx, "_carry"}, bus.carry, e[W]);
`ifdef SERIAL_ALU_FLAGS_EN
    check({pfx, "_zero"}, bus.zero, e[W+1]);
    check({pfx, "_ovf"}, bus.ovf, e[W+2]);
`endif
  endtask

  // ---------------- driver ----------------
  // One full operation: wait for in_ready, present operands, count edges to
  // out_valid, compare, optionally stall out_ready for 'hold' cycles while
  // offering another operand pair, then release.
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input int hold, input bit churn);
    int n;
    logic [W+2:0] e;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_bound", (n < 50), 1);
    bus.op       = op_t'(o);
    bus.a        = av;
    bus.b        = bv;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    exp_q.push_back(model(o, av, bv));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("accept_state", state, S_RUN);
    // the accepting edge counts as edge 1
    n = 1;
    while (!bus.out_valid && n < 4 * W) begin
      if (churn) begin
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        bus.op       = op_t'($urandom_range(0, 3));
        bus.in_valid = 1'b1;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b0;
    check("latency", n, W + 1);
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 1, 0);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    check_out("out", e);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
      @(posedge clk); #1;
      check("hold_out_valid", bus.out_valid, 1);
      check("hold_in_ready", bus.in_ready, 0);
      check_out("hold", e);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    // a pending in_valid must not be taken on the DONE->IDLE edge
    check("release_state", state, S_IDLE);
    check("release_out_valid", bus.out_valid, 0);
    check("release_in_ready", bus.in_ready, 1);
    bus.in_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op        = OP_AND;
    bus.a         = '0;
    bus.b         = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_carry", bus.carry, 0);
    check("rst_state", state, S_IDLE);
`ifdef SERIAL_ALU_FLAGS_EN
    check("rst_zero", bus.zero, 0);
    check("rst_ovf", bus.ovf, 0);
`endif
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(2'b10, 8'hFF, 8'h01, 0, 1'b0);
    do_op(2'b11, 8'h05, 8'h07, 2, 1'b0);
    do_op(2'b11, 8'h80, 8'h01, 0, 1'b0);
    do_op(2'b00, 8'hF0, 8'h3C, 1, 1'b0);
    do_op(2'b01, 8'hF0, 8'h3C, 0, 1'b0);
    do_op(2'b10, 8'h7F, 8'h01, 10, 1'b0);
    do_op(2'b11, 8'h12, 8'h34, 0, 1'b1);
    do_op(2'b10, 8'hA5, 8'h5A, 0, 1'b1);

    // reset while bit 3 is being processed
    bus.op       = OP_ADD;
    bus.a        = 8'h5A;
    bus.b        = 8'h33;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_state_run", state, S_RUN);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", bus.in_ready, 1);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_result", bus.result, 0);
    check("mid_rst_carry", bus.carry, 0);
`ifdef SERIAL_ALU_FLAGS_EN
    check("mid_rst_zero", bus.zero, 0);
    check("mid_rst_ovf", bus.ovf, 0);
`endif
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(2'b10, 8'h5A, 8'h33, 0, 1'b0);

    for (int k = 0; k < 14; k++) begin
      do_op(2'($urandom_range(0, 3)), W'($urandom), W'($urandom),
            $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    check("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
